// File: rtl/al_clk_pkg.sv
// Shared digit limits, BCD field types and hour-format helpers for the
// BCD time-of-day counter.
package al_clk_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0]   digit_t;
    typedef logic [2*DIGIT_W-1:0] bcd_pair_t;

    localparam digit_t DIGIT_MAX        = 4'd9;
    localparam digit_t MIN_SEC_TENS_MAX = 4'd5;
    localparam digit_t HOUR_TENS_MAX    = 4'd2;
    localparam digit_t HOUR_ONES_MAX    = 4'd3;

    function automatic logic bcd_pair_ok(input bcd_pair_t p, input digit_t tens_max);
        return (p[3:0] <= DIGIT_MAX) && (p[7:4] <= tens_max);
    endfunction

    // The ones digit is limited to 3 only when the tens digit is 2.
    function automatic logic hour_field_ok(input bcd_pair_t p);
        return (p[3:0] <= DIGIT_MAX) && (p[7:4] <= HOUR_TENS_MAX) &&
               !((p[7:4] == HOUR_TENS_MAX) && (p[3:0] > HOUR_ONES_MAX));
    endfunction

    function automatic bcd_pair_t hour_to_12h(input bcd_pair_t h);
        logic [4:0] dec;
        dec = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
        if (dec == 5'd0) begin
            return 8'h12;
        end
        if (dec > 5'd12) begin
            dec = dec - 5'd12;
        end
        if (dec >= 5'd10) begin
            return {4'd1, 4'(dec - 5'd10)};
        end
        return {4'd0, dec[3:0]};
    endfunction

endpackage

// File: rtl/al_bcd_digit_pair.sv
// Two-digit BCD counter that wraps to 00 after {WRAP_TENS,WRAP_ONES};
// exposes its next value so the owner can register outputs in the same edge.
module al_bcd_digit_pair
    import al_clk_pkg::*;
#(
    parameter digit_t WRAP_TENS = MIN_SEC_TENS_MAX,
    parameter digit_t WRAP_ONES = DIGIT_MAX
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      load,
    input  bcd_pair_t load_value,
    input  logic      carry_in,
    output bcd_pair_t next_value,
    output logic      carry_out
);

    bcd_pair_t value;
    logic      at_wrap;

    assign at_wrap   = (value == {WRAP_TENS, WRAP_ONES});
    assign carry_out = carry_in & at_wrap;

    always_comb begin
        next_value = value;
        if (load) begin
            next_value = load_value;
        end else if (carry_in) begin
            if (at_wrap) begin
                next_value = '0;
            end else if (value[3:0] == DIGIT_MAX) begin
                next_value = {value[7:4] + 4'd1, 4'd0};
            end else begin
                next_value = {value[7:4], value[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/al_bcd_time_counter.sv
// BCD time-of-day counter (hh:mm[:ss]) with validated loads, manual set
// strobes and a registered 12/24 h display.
module al_bcd_time_counter
    import al_clk_pkg::*;
#(
    parameter  int HAS_SECONDS = 1,
    localparam int TIME_W      = (HAS_SECONDS != 0) ? 24 : 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              one_tick,
    input  logic              mode_12h,
    input  logic [TIME_W-1:0] time_in,
    input  logic              load_new_time,
    input  logic              inc_hour,
    input  logic              inc_min,
    output logic [TIME_W-1:0] current_time_out,
    output logic              pm_out,
    output logic              day_rollover,
    output logic              load_error
);

    bcd_pair_t         hour_in, min_in, hour_next, min_next, hour_disp;
    logic              hour_carry, min_carry, sec_carry;
    logic              sec_ok, load_ok, load_apply, manual, tick_go;
    logic              min_step, hour_step;
    logic [TIME_W-1:0] out_next;

    assign hour_in = time_in[TIME_W-1 -: 8];
    assign min_in  = time_in[TIME_W-9 -: 8];

    assign load_ok    = hour_field_ok(hour_in) & bcd_pair_ok(min_in, MIN_SEC_TENS_MAX) & sec_ok;
    assign load_apply = load_new_time & load_ok;

    // A load (accepted or not) swallows the increments and the tick of its cycle.
    assign manual  = ~load_new_time & (inc_hour | inc_min);
    assign tick_go = ~load_new_time & ~(inc_hour | inc_min) & one_tick;

    assign min_step  = manual ? inc_min  : ((HAS_SECONDS != 0) ? sec_carry : tick_go);
    assign hour_step = manual ? inc_hour : min_carry;

    generate
        if (HAS_SECONDS != 0) begin : g_sec
            bcd_pair_t sec_next;

            assign sec_ok = bcd_pair_ok(time_in[7:0], MIN_SEC_TENS_MAX);

            al_bcd_digit_pair #(
                .WRAP_TENS(MIN_SEC_TENS_MAX),
                .WRAP_ONES(DIGIT_MAX)
            ) u_sec (
                .clk       (clk),
                .reset     (reset),
                .load      (load_apply),
                .load_value(time_in[7:0]),
                .carry_in  (tick_go),
                .next_value(sec_next),
                .carry_out (sec_carry)
            );

            assign out_next = {hour_disp, min_next, sec_next};
        end else begin : g_no_sec
            assign sec_ok    = 1'b1;
            assign sec_carry = 1'b0;
            assign out_next  = {hour_disp, min_next};
        end
    endgenerate

    al_bcd_digit_pair #(
        .WRAP_TENS(MIN_SEC_TENS_MAX),
        .WRAP_ONES(DIGIT_MAX)
    ) u_min (
        .clk       (clk),
        .reset     (reset),
        .load      (load_apply),
        .load_value(min_in),
        .carry_in  (min_step),
        .next_value(min_next),
        .carry_out (min_carry)
    );

    al_bcd_digit_pair #(
        .WRAP_TENS(HOUR_TENS_MAX),
        .WRAP_ONES(HOUR_ONES_MAX)
    ) u_hour (
        .clk       (clk),
        .reset     (reset),
        .load      (load_apply),
        .load_value(hour_in),
        .carry_in  (hour_step),
        .next_value(hour_next),
        .carry_out (hour_carry)
    );

    assign hour_disp = mode_12h ? hour_to_12h(hour_next) : hour_next;

    // Outputs are registered from the next-state time so they move on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            current_time_out <= '0;
            if (mode_12h) begin
                current_time_out[TIME_W-1 -: 8] <= 8'h12;
            end
            pm_out       <= 1'b0;
            day_rollover <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            current_time_out <= out_next;
            pm_out           <= (hour_next >= 8'h12);
            day_rollover     <= tick_go & hour_carry;
            load_error       <= load_new_time & ~load_ok;
        end
    end

endmodule

// File: tb/tb_al_bcd_time_counter.sv
// Directed and randomized check of al_bcd_time_counter against a
// seconds-of-day reference model; also exercises the hh:mm build.
module tb_al_bcd_time_counter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, one_tick, mode_12h, load_new_time, inc_hour, inc_min;
    logic [23:0] time_in;
    logic [23:0] current_time_out;
    logic        pm_out, day_rollover, load_error;

    logic        reset_hm, one_tick_hm, mode_12h_hm, load_new_time_hm, inc_hour_hm, inc_min_hm;
    logic [15:0] time_in_hm;
    logic [15:0] current_time_out_hm;
    logic        pm_out_hm, day_rollover_hm, load_error_hm;

    int checks = 0;
    int errors = 0;

    int mh, mm, ms;
    bit exp_roll, exp_err, exp_mode;

    al_bcd_time_counter dut (
        .clk             (clk),
        .reset           (reset),
        .one_tick        (one_tick),
        .mode_12h        (mode_12h),
        .time_in         (time_in),
        .load_new_time   (load_new_time),
        .inc_hour        (inc_hour),
        .inc_min         (inc_min),
        .current_time_out(current_time_out),
        .pm_out          (pm_out),
        .day_rollover    (day_rollover),
        .load_error      (load_error)
    );

    al_bcd_time_counter #(.HAS_SECONDS(0)) dut_hm (
        .clk             (clk),
        .reset           (reset_hm),
        .one_tick        (one_tick_hm),
        .mode_12h        (mode_12h_hm),
        .time_in         (time_in_hm),
        .load_new_time   (load_new_time_hm),
        .inc_hour        (inc_hour_hm),
        .inc_min         (inc_min_hm),
        .current_time_out(current_time_out_hm),
        .pm_out          (pm_out_hm),
        .day_rollover    (day_rollover_hm),
        .load_error      (load_error_hm)
    );

    function automatic logic [7:0] toBcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int fromBcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [23:0] expTime();
        int hd;
        hd = exp_mode ? (((mh % 12) == 0) ? 12 : (mh % 12)) : mh;
        return {toBcd(hd), toBcd(mm), toBcd(ms)};
    endfunction

    task automatic checkOutput(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: time as seconds of the day, plain arithmetic per event.
    task automatic modelStep(input bit rst, input bit ld, input logic [23:0] tin,
                             input bit tick, input bit ih, input bit im, input bit md);
        bit ok;
        int t;
        exp_roll = 1'b0;
        exp_err  = 1'b0;
        exp_mode = md;
        if (rst) begin
            mh = 0; mm = 0; ms = 0;
        end else if (ld) begin
            ok = 1'b1;
            for (int i = 0; i < 6; i++) begin
                if (tin[i*4 +: 4] > 4'd9) ok = 1'b0;
            end
            if (fromBcd(tin[23:16]) > 23 || fromBcd(tin[15:8]) > 59 || fromBcd(tin[7:0]) > 59) ok = 1'b0;
            if (ok) begin
                mh = fromBcd(tin[23:16]); mm = fromBcd(tin[15:8]); ms = fromBcd(tin[7:0]);
            end else begin
                exp_err = 1'b1;
            end
        end else if (ih || im) begin
            if (ih) mh = (mh + 1) % 24;
            if (im) mm = (mm + 1) % 60;
        end else if (tick) begin
            t = mh * 3600 + mm * 60 + ms + 1;
            if (t == 86400) begin
                t = 0;
                exp_roll = 1'b1;
            end
            mh = t / 3600; mm = (t / 60) % 60; ms = t % 60;
        end
    endtask

    task automatic applyStimulus(input string tag, input bit rst, input bit ld, input logic [23:0] tin,
                                 input bit tick, input bit ih, input bit im, input bit md);
        reset         = rst;
        load_new_time = ld;
        time_in       = tin;
        one_tick      = tick;
        inc_hour      = ih;
        inc_min       = im;
        mode_12h      = md;
        @(posedge clk);
        #1;
        modelStep(rst, ld, tin, tick, ih, im, md);
        checkOutput({tag, "/time"}, current_time_out, expTime());
        checkOutput({tag, "/pm"}, {23'd0, pm_out}, {23'd0, (mh >= 12)});
        checkOutput({tag, "/roll"}, {23'd0, day_rollover}, {23'd0, exp_roll});
        checkOutput({tag, "/lderr"}, {23'd0, load_error}, {23'd0, exp_err});
    endtask

    task automatic stepHm(input bit rst, input bit ld, input logic [15:0] tin, input bit tick, input bit md);
        reset_hm         = rst;
        load_new_time_hm = ld;
        time_in_hm       = tin;
        one_tick_hm      = tick;
        mode_12h_hm      = md;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          rnd_mode;
        logic [23:0] rnd_tin;
        int          sel;

        reset_hm = 1'b1; one_tick_hm = 1'b0; mode_12h_hm = 1'b0;
        load_new_time_hm = 1'b0; inc_hour_hm = 1'b0; inc_min_hm = 1'b0; time_in_hm = '0;

        applyStimulus("reset24", 1, 0, 24'h0, 0, 0, 0, 0);
        applyStimulus("reset12", 1, 0, 24'h0, 0, 0, 0, 1);
        applyStimulus("idle", 0, 0, 24'h0, 0, 0, 0, 0);

        applyStimulus("load235958", 0, 1, 24'h235958, 0, 0, 0, 0);
        applyStimulus("tick235959", 0, 0, 24'h0, 1, 0, 0, 0);
        applyStimulus("tickmidnight", 0, 0, 24'h0, 1, 0, 0, 0);
        applyStimulus("rollclear", 0, 0, 24'h0, 0, 0, 0, 0);

        applyStimulus("badmin", 0, 1, 24'h246000, 0, 0, 0, 0);
        applyStimulus("errclear", 0, 0, 24'h0, 0, 0, 0, 0);
        applyStimulus("baddigit", 0, 1, 24'h12A000, 1, 0, 0, 0);
        applyStimulus("errclear2", 0, 0, 24'h0, 0, 0, 0, 0);

        applyStimulus("pm130500", 0, 1, 24'h130500, 0, 0, 0, 1);
        applyStimulus("am003000", 0, 1, 24'h003000, 0, 0, 0, 1);
        applyStimulus("mode24", 0, 0, 24'h0, 0, 0, 0, 0);

        applyStimulus("load105930", 0, 1, 24'h105930, 0, 0, 0, 0);
        applyStimulus("incmin_tick", 0, 0, 24'h0, 1, 0, 1, 0);
        applyStimulus("load234512", 0, 1, 24'h234512, 0, 0, 0, 0);
        applyStimulus("inchour_wrap", 0, 0, 24'h0, 0, 1, 0, 0);
        applyStimulus("inc_both", 0, 0, 24'h0, 0, 1, 1, 1);

        applyStimulus("load_tick", 0, 1, 24'h080000, 1, 0, 0, 0);
        applyStimulus("reset_load", 1, 1, 24'h235958, 1, 0, 0, 0);

        rnd_mode = 1'b0;
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 2));
            if (sel == 0) begin
                rnd_tin = {toBcd(int'($urandom_range(0, 23))), toBcd(int'($urandom_range(0, 59))),
                           toBcd(int'($urandom_range(0, 59)))};
            end else if (sel == 1) begin
                rnd_tin = {8'h23, 8'h59, toBcd(int'($urandom_range(55, 59)))};
            end else begin
                rnd_tin = 24'($urandom());
            end
            if ($urandom_range(0, 7) == 0) rnd_mode = ~rnd_mode;
            applyStimulus("random",
                          ($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 9) == 0),
                          rnd_tin,
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 15) == 0),
                          rnd_mode);
        end

        stepHm(1, 0, 16'h0, 0, 0);
        checkOutput("hm/reset", {8'd0, current_time_out_hm}, 24'h0);
        stepHm(0, 1, 16'h2359, 0, 0);
        checkOutput("hm/load", {8'd0, current_time_out_hm}, 24'h002359);
        checkOutput("hm/pm", {23'd0, pm_out_hm}, 24'h1);
        stepHm(0, 0, 16'h0, 1, 0);
        checkOutput("hm/tick", {8'd0, current_time_out_hm}, 24'h0);
        checkOutput("hm/roll", {23'd0, day_rollover_hm}, 24'h1);
        stepHm(0, 0, 16'h0, 0, 1);
        checkOutput("hm/rollclear", {23'd0, day_rollover_hm}, 24'h0);
        checkOutput("hm/mode12", {8'd0, current_time_out_hm}, 24'h001200);
        stepHm(0, 1, 16'h2460, 0, 0);
        checkOutput("hm/lderr", {23'd0, load_error_hm}, 24'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/al_bcd_time_counter.md
AL_BCD_TIME_COUNTER -- requirements
Module: al_bcd_time_counter

Interface
REQ-001 SHALL have parameter HAS_SECONDS, default 1, meaning: 1 = hh:mm:ss counter, 0 = hh:mm counter.
REQ-002 SHALL have derived localparam TIME_W, default 24, meaning: 24 if HAS_SECONDS=1, else 16.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port one_tick, input, 1, single-cycle advance strobe (1 s if HAS_SECONDS=1, else 1 min).
REQ-006 SHALL have port mode_12h, input, 1, display select: 0 = 24 h, 1 = 12 h; may change any cycle.
REQ-007 SHALL have port time_in, input, TIME_W, BCD {hh,mm[,ss]}, always 24 h format.
REQ-008 SHALL have port load_new_time, input, 1, single-cycle load strobe for time_in.
REQ-009 SHALL have port inc_hour, input, 1, manual-set strobe: hours +1.
REQ-010 SHALL have port inc_min, input, 1, manual-set strobe: minutes +1.
REQ-011 SHALL have port current_time_out, output, TIME_W, registered BCD time, hour field per mode_12h.
REQ-012 SHALL have port pm_out, output, 1, 1 when internal hour >= 12, independent of mode_12h.
REQ-013 SHALL have port day_rollover, output, 1, one-cycle pulse on a tick-driven midnight wrap.
REQ-014 SHALL have port load_error, output, 1, one-cycle pulse when a load is rejected.

Function
REQ-015 SHALL hold time internally as 24 h BCD digits; hour range 00-23, minute 00-59, second 00-59.
REQ-016 SHALL apply per-cycle priority reset > load_new_time > (inc_hour | inc_min) > one_tick; lower-priority events in the same cycle are dropped, not deferred.
REQ-017 SHALL, on one_tick, increment the least-significant field with BCD carry: ls digit 9->0 carries; sec 59->00 carries to min; min 59->00 carries to hour; hour 09->10, 19->20, 23->00.
REQ-018 SHALL pulse day_rollover in the cycle after a tick takes 23:59[:59] to 00:00[:00]; manual increments never pulse it.
REQ-019 SHALL, on inc_min, wrap minutes 59->00 with no carry into hours; seconds are unchanged.
REQ-020 SHALL, on inc_hour, wrap hours 23->00; minutes and seconds are unchanged; inc_hour and inc_min together both apply.
REQ-021 SHALL accept a load only if every digit is <= 9, hh <= 23, mm <= 59 and ss <= 59; an accepted load updates the time one cycle later.
REQ-022 SHALL, on a rejected load, keep the time unchanged and pulse load_error the next cycle; the tick or increment in that cycle is still dropped.
REQ-023 SHALL drive current_time_out hour in 12 h mode as internal 00->12, 01-12 unchanged, 13-23 -> 01-11; minute and second fields are identical in both modes.
REQ-024 SHALL register all outputs; a mode_12h change is visible on current_time_out one cycle later.

Reset
REQ-025 SHALL, on reset, set internal time to 00:00[:00] and clear pm_out, day_rollover and load_error in the next cycle.
REQ-026 SHALL make current_time_out equal to 0 (24 h) or 0x12 in the hour field (12 h) after reset.
REQ-027 SHALL let reset asserted mid-operation, including in a load cycle, override every other input.

Structure
REQ-028 SHALL place digit limits (9, 5, 2, 3), the BCD digit width and the 24->12 h hour mapping function in the shared package al_clk_pkg.
REQ-029 SHALL use the sub-module al_bcd_digit_pair, a two-digit BCD modulo-N counter with carry-in, wrap value and carry-out, instantiated once per field.

Verification
REQ-030 SHALL cover: reset, then load 24'h235958 with one_tick on 2 cycles -> 23:59:59, then 00:00:00, day_rollover = 1 for exactly 1 cycle.
REQ-031 SHALL cover: load 24'h246000 -> load_error pulses once and time is unchanged; load 24'h12A000 -> same.
REQ-032 SHALL cover: time 13:05:00 with mode_12h = 1 -> current_time_out = 24'h010500 and pm_out = 1; time 00:30:00 -> 24'h123000 and pm_out = 0.
REQ-033 SHALL cover: time 10:59:30, inc_min and one_tick in the same cycle -> 10:00:30, tick dropped; inc_hour at 23:xx -> 00:xx with no rollover pulse.
REQ-034 SHALL cover: load_new_time and one_tick together with time_in = 24'h080000 -> 08:00:00 exactly; reset during the load -> 00:00:00.
REQ-035 SHALL cover: HAS_SECONDS = 0 build with time 23:59 and one tick -> 16'h0000 and a day_rollover pulse.
